// File: rtl/bcd_stopwatch.sv
// Two-digit BCD stopwatch: synchronized, debounced start/stop and clear buttons,
// a prescaled up/down count with a wrap pulse on 99<->00.
module bcd_stopwatch #(
  parameter int TICK_DIV        = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       up_down,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       wrap
);

  localparam logic        STOPPED = 1'b0;
  localparam logic        RUNNING = 1'b1;
  localparam logic [16:0] DB_LAST = 17'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] PS_LAST = 24'(TICK_DIV - 1);

  // Bit 0 = start_stop, bit 1 = clear, bit 2 = up_down.
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [1:0]       db_q, db_d;
  logic [1:0][16:0] db_cnt_q, db_cnt_d;
  logic [1:0]       press_q, press_d;
  logic             state_q, state_d;
  logic [23:0]      presc_q, presc_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             wrap_q, wrap_d;
  logic             step;

  always_comb begin
    sync1_d = {up_down, btn_clear, btn_start_stop};
    sync2_d = sync1_q;
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 17'd1;
      end
    end
    press_d = db_d & ~db_q;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    wrap_d  = 1'b0;
    step    = 1'b0;

    if (state_q == RUNNING) begin
      if (presc_q == PS_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end

    if (step) begin
      if (sync2_q[2]) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          if (tens_q == 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          if (tens_q == 4'd0) begin
            tens_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q - 4'd1;
          end
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end

    // Clear outranks both a coincident start/stop press and a same-edge step.
    if (press_q[1]) begin
      state_d = STOPPED;
      presc_d = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      wrap_d  = 1'b0;
    end else if (press_q[0]) begin
      state_d = ~state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_cnt_q <= '0;
      press_q  <= '0;
      state_q  <= STOPPED;
      presc_q  <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      presc_q  <= presc_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      wrap_q   <= wrap_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = state_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: expectations are queued with the cycle at
// which they must hold and checked on the falling edge of that cycle.
module tb_bcd_stopwatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       up_down;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       wrap;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  int         q_at[$];
  string      q_tag[$];
  logic [9:0] q_val[$];

  bcd_stopwatch #(
    .TICK_DIV       (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .up_down       (up_down),
    .tens          (tens),
    .ones          (ones),
    .running       (running),
    .wrap          (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, actual, expected);
    end
  endtask

  // Expected value layout: {tens, ones, running, wrap}; queue kept sorted by cycle.
  task automatic expectOutput(input int at, input string tag, input logic [3:0] t,
                              input logic [3:0] o, input logic r, input logic w);
    int i = 0;
    while (i < q_at.size() && q_at[i] <= at) i++;
    q_at.insert(i, at);
    q_tag.insert(i, tag);
    q_val.insert(i, {t, o, r, w});
  endtask

  task automatic applyStimulus(input logic ss, input logic clr, input logic ud, input logic rst);
    btn_start_stop = ss;
    btn_clear      = clr;
    up_down        = ud;
    reset          = rst;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    int         at;
    string      tag;
    logic [9:0] val;
    while (q_at.size() > 0 && q_at[0] <= cyc) begin
      at  = q_at.pop_front();
      tag = q_tag.pop_front();
      val = q_val.pop_front();
      if (at == cyc)
        checkOutput(tag, {22'd0, tens, ones, running, wrap}, {22'd0, val});
      else
        checkOutput({tag, "_missed"}, 32'hFFFF_FFFF, {22'd0, val});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, c, s, r, c2, limit;

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    expectOutput(cyc, "reset_state", 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(cyc + 4);

    // Bounce: 2-cycle raw pulses must never be accepted as a press.
    k = cyc;
    expectOutput(k + 5,  "bounce_a", 4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(k + 15, "bounce_b", 4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(k + 25, "bounce_c", 4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(k + 32, "bounce_d", 4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i / 2) % 2) == 0, 1'b0, 1'b1, 1'b0);
      waitUntil(k + i + 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(k + 34);

    // Start latency, carry, and the full up-count through 99 -> 00.
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expectOutput(k + 6,    "start_early", 4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(k + 7,    "start_run",   4'd0, 4'd0, 1'b1, 1'b0);
    expectOutput(k + 16,   "pre_step1",   4'd0, 4'd0, 1'b1, 1'b0);
    expectOutput(k + 17,   "step1",       4'd0, 4'd1, 1'b1, 1'b0);
    expectOutput(k + 97,   "up_09",       4'd0, 4'd9, 1'b1, 1'b0);
    expectOutput(k + 107,  "carry_10",    4'd1, 4'd0, 1'b1, 1'b0);
    expectOutput(k + 987,  "up_98",       4'd9, 4'd8, 1'b1, 1'b0);
    expectOutput(k + 997,  "up_99",       4'd9, 4'd9, 1'b1, 1'b0);
    expectOutput(k + 1006, "hold_99",     4'd9, 4'd9, 1'b1, 1'b0);
    expectOutput(k + 1007, "wrap_up",     4'd0, 4'd0, 1'b1, 1'b1);
    expectOutput(k + 1008, "wrap_up_end", 4'd0, 4'd0, 1'b1, 1'b0);
    waitUntil(k + 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Down-count through 00 -> 99 and the 10 -> 09 borrow.
    waitUntil(k + 1008);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expectOutput(k + 1017, "wrap_down",     4'd9, 4'd9, 1'b1, 1'b1);
    expectOutput(k + 1018, "wrap_down_end", 4'd9, 4'd9, 1'b1, 1'b0);
    expectOutput(k + 1027, "down_98",       4'd9, 4'd8, 1'b1, 1'b0);
    expectOutput(k + 1907, "down_10",       4'd1, 4'd0, 1'b1, 1'b0);
    expectOutput(k + 1917, "borrow_09",     4'd0, 4'd9, 1'b1, 1'b0);
    waitUntil(k + 1918);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectOutput(k + 1927, "up_again_10", 4'd1, 4'd0, 1'b1, 1'b0);
    expectOutput(k + 2197, "up_37",       4'd3, 4'd7, 1'b1, 1'b0);

    // Coincident start/stop and clear at 37: clear wins.
    waitUntil(k + 2198);
    c = cyc;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    expectOutput(c + 6,  "both_early", 4'd3, 4'd7, 1'b1, 1'b0);
    expectOutput(c + 7,  "both_clear", 4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(c + 17, "both_held",  4'd0, 4'd0, 1'b0, 1'b0);
    waitUntil(c + 8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Restart from a cleared prescaler, pause at 3 of 10, resume.
    waitUntil(c + 20);
    s = cyc;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expectOutput(s + 7,  "restart_run",  4'd0, 4'd0, 1'b1, 1'b0);
    expectOutput(s + 16, "restart_pre",  4'd0, 4'd0, 1'b1, 1'b0);
    expectOutput(s + 17, "restart_step", 4'd0, 4'd1, 1'b1, 1'b0);
    expectOutput(s + 19, "pause_early",  4'd0, 4'd1, 1'b1, 1'b0);
    expectOutput(s + 20, "pause",        4'd0, 4'd1, 1'b0, 1'b0);
    expectOutput(s + 25, "paused_hold",  4'd0, 4'd1, 1'b0, 1'b0);
    waitUntil(s + 7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(s + 13);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitUntil(s + 20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(s + 30);
    r = cyc;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expectOutput(r + 6,   "resume_early", 4'd0, 4'd1, 1'b0, 1'b0);
    expectOutput(r + 7,   "resume_run",   4'd0, 4'd1, 1'b1, 1'b0);
    expectOutput(r + 13,  "resume_pre",   4'd0, 4'd1, 1'b1, 1'b0);
    expectOutput(r + 14,  "resume_step",  4'd0, 4'd2, 1'b1, 1'b0);
    expectOutput(r + 443, "up_44",        4'd4, 4'd4, 1'b1, 1'b0);
    expectOutput(r + 444, "up_45",        4'd4, 4'd5, 1'b1, 1'b0);
    waitUntil(r + 7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-run with start/stop held through the release.
    waitUntil(r + 446);
    c2 = cyc;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    expectOutput(c2 + 1, "reset_run",     4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(c2 + 2, "reset_hold",    4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(c2 + 8, "held_early",    4'd0, 4'd0, 1'b0, 1'b0);
    expectOutput(c2 + 9, "held_run",      4'd0, 4'd0, 1'b1, 1'b0);
    waitUntil(c2 + 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitUntil(c2 + 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    limit = cyc + 50;
    while (q_at.size() > 0 && cyc < limit) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain", 32'(q_at.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
